id_stage: RTL

- Instruction decode stage directly upstream of the 16-entry register file.
- Takes fetched ARM instruction words, drives the register file read addresses, and decodes each word into a registered execute-stage bundle.
- Tracks outstanding register writes in a scoreboard and stalls fetch on RAW/WAW hazards.
- The register file has registered read outputs, so its out1/out2 line up with this block's ex_* outputs one cycle after accept.

---
 rtl/id_stage_if.sv | 54 +++++
 rtl/id_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_if.sv
// Decode-stage bus bundle: fetch request, writeback retire, register file
// read addresses and the registered execute bundle.
interface id_stage_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int FULLW      = 32
);
  // fetch side
  logic                  instr_valid;
  logic [FULLW-1:0]      instr;
  logic [FULLW-1:0]      instr_addr;
  logic                  instr_ready;
  logic                  flush;
  // writeback retire
  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  // register file read addresses
  logic [ADDR_WIDTH-1:0] rf_in1;
  logic [ADDR_WIDTH-1:0] rf_in2;
  // execute bundle
  logic                  ex_valid;
  logic                  ex_ready;
  logic [3:0]            ex_cond;
  logic [3:0]            ex_op;
  logic                  ex_setflags;
  logic [ADDR_WIDTH-1:0] ex_rd;
  logic                  ex_we;
  logic [FULLW-1:0]      ex_imm;
  logic                  ex_use_imm;
  logic [7:0]            ex_shift;
  logic                  ex_is_mem;
  logic                  ex_is_load;
  logic                  ex_mem_up;
  logic                  ex_mem_byte;
  logic                  ex_is_branch;
  logic                  ex_link;
  logic                  ex_undef;
  logic [FULLW-1:0]      ex_pc;

  // decode stage view
  modport slave (
    input  instr_valid, instr, instr_addr, flush, wb_valid, wb_addr, ex_ready,
    output instr_ready, rf_in1, rf_in2, ex_valid, ex_cond, ex_op, ex_setflags,
           ex_rd, ex_we, ex_imm, ex_use_imm, ex_shift, ex_is_mem, ex_is_load,
           ex_mem_up, ex_mem_byte, ex_is_branch, ex_link, ex_undef, ex_pc
  );

  // surrounding pipeline view (fetch, writeback, execute)
  modport master (
    output instr_valid, instr, instr_addr, flush, wb_valid, wb_addr, ex_ready,
    input  instr_ready, rf_in1, rf_in2, ex_valid, ex_cond, ex_op, ex_setflags,
           ex_rd, ex_we, ex_imm, ex_use_imm, ex_shift, ex_is_mem, ex_is_load,
           ex_mem_up, ex_mem_byte, ex_is_branch, ex_link, ex_undef, ex_pc
  );
endinterface

// File: rtl/id_stage.sv
// ARM instruction decode stage: drives register file read addresses,
// decodes into a registered execute bundle and stalls fetch on RAW/WAW
// hazards against a scoreboard of outstanding register writes.
module id_stage #(
  parameter int ADDR_WIDTH = 4,
  parameter int FULLW      = 32
) (
  input logic      clk,
  input logic      reset,
  id_stage_if.slave bus
);

  localparam int                    NREG   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_REG = ADDR_WIDTH'(NREG - 1);
  localparam logic [ADDR_WIDTH-1:0] LR_REG = ADDR_WIDTH'(NREG - 2);
  localparam logic [3:0]            OP_ADD = 4'b0100;

  typedef struct packed {
    logic [3:0]            cond;
    logic [3:0]            op;
    logic                  setflags;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  we;
    logic [FULLW-1:0]      imm;
    logic                  use_imm;
    logic [7:0]            shift;
    logic                  is_mem;
    logic                  is_load;
    logic                  mem_up;
    logic                  mem_byte;
    logic                  is_branch;
    logic                  link;
    logic                  undef;
    logic [FULLW-1:0]      pc;
  } bundle_t;

  // registered state
  bundle_t               ex_q;
  logic                  ex_valid_q, ex_valid_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q;
  logic [NREG-2:0]       pend_q, pend_d;

  // decode results
  bundle_t               dec;
  logic                  d_u1, d_u2, d_u3;
  logic [ADDR_WIDTH-1:0] d_r1, d_r2, d_r3;
  logic [5:0]            rot;
  logic [FULLW-1:0]      imm8;
  logic [FULLW-1:0]      dp_imm;

  logic [NREG-1:0]       pend_all;
  logic                  src_hz, wr_hz, hazard, out_stall, ready, accept;
  logic [ADDR_WIDTH-1:0] src1, src2;

  // rotated DP immediate: imm8 rotated right by twice the rotate field
  always_comb begin
    rot    = {instr_rot(bus.instr), 1'b0};
    imm8   = {{(FULLW-8){1'b0}}, bus.instr[7:0]};
    dp_imm = (imm8 >> rot) | (imm8 << (6'd32 - rot));
  end

  function automatic logic [3:0] instr_rot(input logic [FULLW-1:0] w);
    return w[11:8];
  endfunction

  // combinational decode of the presented instruction and its source set
  always_comb begin
    dec      = '0;
    d_u1     = 1'b0;
    d_u2     = 1'b0;
    d_u3     = 1'b0;
    d_r1     = '0;
    d_r2     = '0;
    d_r3     = '0;
    dec.cond = bus.instr[31:28];
    dec.pc   = bus.instr_addr;
    if (bus.instr[31:28] == 4'hF) begin
      dec.undef = 1'b1;
    end else begin
      unique case (bus.instr[27:25])
        3'b000, 3'b001: begin
          dec.op       = bus.instr[24:21];
          dec.setflags = bus.instr[20];
          dec.rd       = bus.instr[15:12];
          // compare/test opcodes (TST..CMN) produce flags only
          dec.we       = (bus.instr[24:23] != 2'b10);
          // MOV/MVN ignore Rn
          d_u1         = !(bus.instr[24:21] == 4'b1101 || bus.instr[24:21] == 4'b1111);
          d_r1         = bus.instr[19:16];
          if (bus.instr[25]) begin
            dec.use_imm = 1'b1;
            dec.imm     = dp_imm;
          end else begin
            d_u2      = 1'b1;
            d_r2      = bus.instr[3:0];
            dec.shift = bus.instr[11:4];
          end
        end
        3'b010, 3'b011: begin
          dec.op       = OP_ADD;
          dec.is_mem   = 1'b1;
          dec.is_load  = bus.instr[20];
          dec.mem_up   = bus.instr[23];
          dec.mem_byte = bus.instr[22];
          dec.rd       = bus.instr[15:12];
          dec.we       = bus.instr[20];
          dec.imm      = {{(FULLW-12){1'b0}}, bus.instr[11:0]};
          dec.use_imm  = ~bus.instr[25];
          d_u1         = 1'b1;
          d_r1         = bus.instr[19:16];
          if (bus.instr[25]) dec.shift = bus.instr[11:4];
          if (bus.instr[20]) begin
            d_u2 = bus.instr[25];
            d_r2 = bus.instr[3:0];
          end else begin
            // store data takes port 2; a register offset is still
            // hazard-checked so it cannot be read stale by execute
            d_u2 = 1'b1;
            d_r2 = bus.instr[15:12];
            d_u3 = bus.instr[25];
            d_r3 = bus.instr[3:0];
          end
        end
        3'b101: begin
          dec.op        = OP_ADD;
          dec.is_branch = 1'b1;
          dec.use_imm   = 1'b1;
          dec.imm       = {{(FULLW-26){bus.instr[23]}}, bus.instr[23:0], 2'b00};
          if (bus.instr[24]) begin
            dec.link = 1'b1;
            dec.rd   = LR_REG;
            dec.we   = 1'b1;
          end
        end
        default: dec.undef = 1'b1;
      endcase
    end
  end

  // hazard detection against the registered scoreboard only
  always_comb begin
    pend_all  = {1'b0, pend_q};
    src_hz    = (d_u1 & pend_all[d_r1]) | (d_u2 & pend_all[d_r2]) |
                (d_u3 & pend_all[d_r3]);
    wr_hz     = dec.we & pend_all[dec.rd];
    hazard    = bus.instr_valid & (src_hz | wr_hz);
    out_stall = ex_valid_q & ~bus.ex_ready;
    ready     = ~reset & ~hazard & ~bus.flush & ~out_stall;
    accept    = bus.instr_valid & ready;
    src1      = d_u1 ? d_r1 : '0;
    src2      = d_u2 ? d_r2 : '0;
  end

  // scoreboard update: retire and flush clear first, a new accept sets last
  always_comb begin
    pend_d = pend_q;
    if (bus.wb_valid && bus.wb_addr != PC_REG)
      pend_d[bus.wb_addr] = 1'b0;
    if (bus.flush && ex_valid_q && ex_q.we && ex_q.rd != PC_REG)
      pend_d[ex_q.rd] = 1'b0;
    if (accept && dec.we && dec.rd != PC_REG)
      pend_d[dec.rd] = 1'b1;
  end

  // execute bundle valid: flush kills, accept loads, consume drains
  always_comb begin
    ex_valid_d = ex_valid_q;
    if (bus.flush)        ex_valid_d = 1'b0;
    else if (accept)      ex_valid_d = 1'b1;
    else if (bus.ex_ready) ex_valid_d = 1'b0;
  end

  // state registers; bundle and held sources only change on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      pend_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      pend_q     <= pend_d;
      if (accept) begin
        ex_q  <= dec;
        rs1_q <= src1;
        rs2_q <= src2;
      end
    end
  end

  // read addresses track the held bundle so the registered RF outputs
  // stay aligned with ex_* while execute stalls
  assign bus.instr_ready  = ready;
  assign bus.rf_in1       = accept ? src1 : rs1_q;
  assign bus.rf_in2       = accept ? src2 : rs2_q;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_cond      = ex_q.cond;
  assign bus.ex_op        = ex_q.op;
  assign bus.ex_setflags  = ex_q.setflags;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_we        = ex_q.we;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_use_imm   = ex_q.use_imm;
  assign bus.ex_shift     = ex_q.shift;
  assign bus.ex_is_mem    = ex_q.is_mem;
  assign bus.ex_is_load   = ex_q.is_load;
  assign bus.ex_mem_up    = ex_q.mem_up;
  assign bus.ex_mem_byte  = ex_q.mem_byte;
  assign bus.ex_is_branch = ex_q.is_branch;
  assign bus.ex_link      = ex_q.link;
  assign bus.ex_undef     = ex_q.undef;
  assign bus.ex_pc        = ex_q.pc;

endmodule
